// File: rtl/axi_wr_burst_master_pkg.sv
// Package for axi_wr_burst_master: FSM state type, AXI encodings and the 4 KB
// boundary helper used when AXI_WR_4K_CHECK_EN is defined.
package axi_wr_burst_master_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StResp
    } state_e;

    localparam logic [1:0]  AxiBurstIncr   = 2'b01;
    localparam logic [3:0]  AxiCacheBufMod = 4'b0011;
    localparam int unsigned Axi4kBytes     = 4096;

    // True when a burst of (len+1) beats starting at page offset 'offset' runs past the 4 KB page.
    function automatic logic crosses_4k(input logic [11:0] offset, input logic [7:0] len,
                                        input int unsigned beat_bytes);
        int unsigned span;
        span = (32'(len) + 32'd1) * beat_bytes;
        return (32'(offset) + span) > Axi4kBytes;
    endfunction

endpackage

// File: rtl/axi_wr_burst_master_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst master and the interconnect.
// Modports: master (drives AW/W payload and valids, BREADY) and slave (the reverse).
interface axi_wr_burst_master_if #(
    parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512
);
    logic [C_M_AXI_ID_WIDTH-1:0]     awid;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]                      awlen;
    logic [2:0]                      awsize;
    logic [1:0]                      awburst;
    logic                            awlock;
    logic [3:0]                      awcache;
    logic [2:0]                      awprot;
    logic [3:0]                      awqos;
    logic                            awvalid;
    logic                            awready;

    logic [C_M_AXI_ID_WIDTH-1:0]     wid;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wlast;
    logic                            wvalid;
    logic                            wready;

    logic [C_M_AXI_ID_WIDTH-1:0]     bid;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_wr_burst_master.sv
// Single-outstanding AXI4 INCR write-burst engine.
// Takes one command (address, AWLEN-encoded beat count), streams the data beats straight through
// to the W channel, waits for the B response and reports completion (done) and a sticky error.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/addr/len      command handshake (ready only in idle)
//   din_valid/din_ready/data/strb     data beat stream, passed through to W
//   busy, done, err, err_clr          status: not idle, B-handshake pulse, sticky error, clear
//   m_axi                             AXI4 AW/W/B master channels
// Build option: define AXI_WR_4K_CHECK_EN to reject commands whose burst crosses a 4 KB page
// (no AW/W issued, err set, done pulsed the next cycle).
module axi_wr_burst_master
    import axi_wr_burst_master_pkg::*;
#(
    parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]                      cmd_len,

    input  logic                            din_valid,
    output logic                            din_ready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   din_data,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] din_strb,

    output logic                            busy,
    output logic                            done,
    output logic                            err,
    input  logic                            err_clr,

    axi_wr_burst_master_if.master           m_axi
);

    localparam int unsigned BeatBytes = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned SizeLog2  = $clog2(BeatBytes);
    localparam logic [2:0]  AwSize    = 3'(SizeLog2);

    state_e                          state_q;
    logic                            cmd_ready_q;
    logic                            awvalid_q;
    logic                            bready_q;
    logic                            aw_done_q;
    logic                            w_done_q;
    logic                            err_q;
    logic                            done_rej_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q;
    logic [7:0]                      awlen_q;
    logic [7:0]                      beat_cnt_q;

    logic cmd_hs, aw_hs, w_hs, b_hs, beats_left, w_last, reject_cmd;

    assign cmd_hs     = cmd_valid & cmd_ready_q;
    assign beats_left = (state_q == StXfer) & ~w_done_q;
    assign w_last     = (beat_cnt_q == awlen_q);
    assign aw_hs      = awvalid_q & m_axi.awready;
    assign w_hs       = beats_left & din_valid & m_axi.wready;
    assign b_hs       = bready_q & m_axi.bvalid;

`ifdef AXI_WR_4K_CHECK_EN
    assign reject_cmd = crosses_4k(cmd_addr[11:0], cmd_len, BeatBytes);
`else
    assign reject_cmd = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_q       <= 1'b0;
            done_rej_q  <= 1'b0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            beat_cnt_q  <= '0;
        end else begin
            done_rej_q <= 1'b0;

            // A new error outranks a same-cycle clear.
            if ((b_hs & m_axi.bresp[1]) | (cmd_hs & reject_cmd)) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (cmd_hs) begin
                        cmd_ready_q <= 1'b0;
                        if (reject_cmd) begin
                            done_rej_q <= 1'b1;
                        end else begin
                            state_q    <= StXfer;
                            awvalid_q  <= 1'b1;
                            awaddr_q   <= {cmd_addr[C_M_AXI_ADDR_WIDTH-1:SizeLog2],
                                           {SizeLog2{1'b0}}};
                            awlen_q    <= cmd_len;
                            beat_cnt_q <= '0;
                            aw_done_q  <= 1'b0;
                            w_done_q   <= 1'b0;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                StXfer: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    // Counter saturates at len; the final beat flags completion instead.
                    if (w_hs) begin
                        if (w_last) begin
                            w_done_q <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                        end
                    end
                    if ((aw_done_q | aw_hs) & (w_done_q | (w_hs & w_last))) begin
                        state_q  <= StResp;
                        bready_q <= 1'b1;
                    end
                end
                StResp: begin
                    if (b_hs) begin
                        bready_q    <= 1'b0;
                        state_q     <= StIdle;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign din_ready = beats_left & m_axi.wready;
    assign busy      = (state_q != StIdle);
    assign done      = b_hs | done_rej_q;
    assign err       = err_q;

    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awlen   = awlen_q;
    assign m_axi.awsize  = AwSize;
    assign m_axi.awburst = AxiBurstIncr;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = AxiCacheBufMod;
    assign m_axi.awprot  = '0;
    assign m_axi.awqos   = '0;
    assign m_axi.awvalid = awvalid_q;

    assign m_axi.wid     = '0;
    assign m_axi.wdata   = din_data;
    assign m_axi.wstrb   = din_strb;
    assign m_axi.wlast   = w_last & beats_left;
    assign m_axi.wvalid  = din_valid & beats_left;

    assign m_axi.bready  = bready_q;

    logic unused_sigs;
    assign unused_sigs = ^{m_axi.bid, m_axi.bresp[0], cmd_addr[SizeLog2-1:0]};

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Directed bench for axi_wr_burst_master (512-bit data, 32-bit address).
module tb_axi_wr_burst_master;

    localparam int unsigned IW = 1;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 512;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [DW-1:0] din_data = '0;
    logic [SW-1:0] din_strb = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic          err_clr = 1'b0;

    always #5 clk = ~clk;

    axi_wr_burst_master_if #(
        .C_M_AXI_ID_WIDTH  (IW),
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW)
    ) axi ();

    axi_wr_burst_master #(
        .C_M_AXI_ID_WIDTH  (IW),
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .din_data (din_data),
        .din_strb (din_strb),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_clr  (err_clr),
        .m_axi    (axi)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;
    int burst_no = 0;

    // Observations recorded by drive_burst for the calling test to judge.
    int r_beats, r_aw_hs, r_aw_lat, r_aw_cyc, r_last_w_cyc, r_ready_wait;
    int r_aw_bad, r_data_err, r_last_err, r_ctl_err, r_done, r_spur_done;
    bit r_timeout;

    function automatic logic [DW-1:0] beat_data(input int b, input int i);
        logic [31:0] w;
        w = 32'(b * 256 + i);
        return {16{w}};
    endfunction

    function automatic logic [SW-1:0] beat_strb(input int b, input int i);
        return {32'(b), ~32'(i)};
    endfunction

    initial begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bid     = '0;
    end

    // Plays one command plus its slave side; called at a negedge, returns at a negedge.
    task automatic drive_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                               input int aw_wait, input bit stall, input logic [1:0] resp,
                               input bit clr_at_b);
        int cyc;
        bit b_pend;
        bit fin;
        logic exp_ready;
        logic [AW-1:0] exp_addr;
        exp_addr = {addr[AW-1:6], 6'b0};
        r_beats = 0; r_aw_hs = 0; r_aw_lat = -1; r_aw_cyc = -1; r_last_w_cyc = -1;
        r_ready_wait = 0; r_aw_bad = 0; r_data_err = 0; r_last_err = 0; r_ctl_err = 0;
        r_done = 0; r_spur_done = 0; r_timeout = 0;
        burst_no++;
        cmd_addr = addr;
        cmd_len = len;
        cmd_valid = 1'b1;
        #1;
        while (!cmd_ready && r_ready_wait < 50) begin
            @(negedge clk);
            #1;
            r_ready_wait++;
        end
        if (!cmd_ready) begin
            r_timeout = 1;
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        fin = 0;
        while (!fin && cyc < 3000) begin
            cyc++;
            b_pend = (r_aw_hs > 0) && (r_beats == int'(len) + 1);
            din_valid   = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            din_data    = beat_data(burst_no, r_beats);
            din_strb    = beat_strb(burst_no, r_beats);
            axi.awready = (cyc > aw_wait) && (stall ? ($urandom_range(0, 1) == 1) : 1'b1);
            axi.wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            axi.bvalid  = b_pend && (stall ? ($urandom_range(0, 1) == 1) : 1'b1);
            axi.bresp   = resp;
            err_clr     = clr_at_b && axi.bvalid;
            #1;
            if (axi.awvalid !== (r_aw_hs == 0)) r_ctl_err++;
            if (axi.bready !== b_pend) r_ctl_err++;
            if (busy !== 1'b1) r_ctl_err++;
            exp_ready = axi.wready && (r_beats <= int'(len));
            if (din_ready !== exp_ready) r_ctl_err++;
            if (axi.wvalid !== (din_valid && r_beats <= int'(len))) r_ctl_err++;
            if (axi.awvalid === 1'b1) begin
                if (r_aw_lat < 0) r_aw_lat = cyc;
                if (axi.awaddr !== exp_addr || axi.awlen !== len || axi.awsize !== 3'd6 ||
                    axi.awburst !== 2'b01 || axi.awcache !== 4'b0011 || axi.awid !== '0 ||
                    axi.awlock !== 1'b0 || axi.awprot !== 3'd0 || axi.awqos !== 4'd0)
                    r_aw_bad++;
                if (axi.awready) begin
                    r_aw_hs++;
                    r_aw_cyc = cyc;
                end
            end
            if (axi.wvalid === 1'b1 && axi.wready) begin
                if (axi.wdata !== beat_data(burst_no, r_beats) ||
                    axi.wstrb !== beat_strb(burst_no, r_beats) || axi.wid !== '0)
                    r_data_err++;
                if (axi.wlast !== (r_beats == int'(len))) r_last_err++;
                r_beats++;
                r_last_w_cyc = cyc;
            end
            if (axi.bvalid && axi.bready === 1'b1) begin
                if (done === 1'b1) r_done++;
                fin = 1;
            end else if (done !== 1'b0) begin
                r_spur_done++;
            end
            @(negedge clk);
        end
        if (!fin) r_timeout = 1;
        din_valid = 1'b0;
        axi.awready = 1'b0;
        axi.wready = 1'b0;
        axi.bvalid = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        din_valid = 1'b1;
        axi.wready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_cnt++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready); else pass_cnt++;
        chk_cnt++; if (axi.awvalid !== 1'b0) $display("FAIL rst_awvalid: got %b expected 0", axi.awvalid); else pass_cnt++;
        chk_cnt++; if ({axi.wvalid, din_ready, axi.bready} !== 3'b000) $display("FAIL rst_w_b: got %b expected 000", {axi.wvalid, din_ready, axi.bready}); else pass_cnt++;
        chk_cnt++; if ({busy, done, err} !== 3'b000) $display("FAIL rst_status: got %b expected 000", {busy, done, err}); else pass_cnt++;
        chk_cnt++; if ({axi.awaddr, axi.awlen} !== 40'd0) $display("FAIL rst_aw_fields: got %h expected 0", {axi.awaddr, axi.awlen}); else pass_cnt++;
        chk_cnt++; if ({axi.awsize, axi.awburst, axi.awcache} !== 9'b110_01_0011) $display("FAIL rst_aw_const: got %b expected 110010011", {axi.awsize, axi.awburst, axi.awcache}); else pass_cnt++;
        rst_n = 1'b1;
        din_valid = 1'b0;
        axi.wready = 1'b0;
        @(negedge clk);
        #1;
        chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", cmd_ready); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_basic();
        drive_burst(32'h0000_1000, 8'd3, 0, 1'b0, 2'b00, 1'b0);
        chk_cnt++; if (r_timeout !== 1'b0) $display("FAIL basic_timeout: got %b expected 0", r_timeout); else pass_cnt++;
        chk_cnt++; if (r_beats !== 4) $display("FAIL basic_beats: got %0d expected 4", r_beats); else pass_cnt++;
        chk_cnt++; if (r_aw_lat !== 1) $display("FAIL basic_aw_latency: got %0d expected 1", r_aw_lat); else pass_cnt++;
        chk_cnt++; if (r_aw_hs !== 1) $display("FAIL basic_aw_count: got %0d expected 1", r_aw_hs); else pass_cnt++;
        chk_cnt++; if (r_aw_bad !== 0) $display("FAIL basic_aw_fields: got %0d bad expected 0", r_aw_bad); else pass_cnt++;
        chk_cnt++; if (r_data_err + r_last_err !== 0) $display("FAIL basic_w_data_last: got %0d errors expected 0", r_data_err + r_last_err); else pass_cnt++;
        chk_cnt++; if (r_ctl_err !== 0) $display("FAIL basic_control: got %0d errors expected 0", r_ctl_err); else pass_cnt++;
        chk_cnt++; if (r_done !== 1 || r_spur_done !== 0) $display("FAIL basic_done: got %0d/%0d expected 1/0", r_done, r_spur_done); else pass_cnt++;
        #1;
        chk_cnt++; if ({done, busy, err} !== 3'b000) $display("FAIL basic_after: got %b expected 000", {done, busy, err}); else pass_cnt++;
    endtask

    task automatic test_w_before_aw();
        drive_burst(32'h0000_2000, 8'd3, 4, 1'b0, 2'b00, 1'b0);
        chk_cnt++; if (r_beats !== 4 || r_timeout) $display("FAIL early_w_beats: got %0d expected 4", r_beats); else pass_cnt++;
        chk_cnt++; if ((r_last_w_cyc < r_aw_cyc) !== 1'b1) $display("FAIL early_w_order: got last_w %0d aw %0d expected last_w before aw", r_last_w_cyc, r_aw_cyc); else pass_cnt++;
        chk_cnt++; if (r_data_err + r_last_err + r_ctl_err + r_aw_bad !== 0) $display("FAIL early_w_errors: got %0d expected 0", r_data_err + r_last_err + r_ctl_err + r_aw_bad); else pass_cnt++;
        chk_cnt++; if (r_done !== 1 || r_spur_done !== 0) $display("FAIL early_w_done: got %0d/%0d expected 1/0", r_done, r_spur_done); else pass_cnt++;
    endtask

    task automatic test_err();
        drive_burst(32'h0000_2040, 8'd0, 0, 1'b0, 2'b10, 1'b0);
        chk_cnt++; if (r_beats !== 1 || r_last_err !== 0) $display("FAIL len0_beat: got %0d beats %0d last errs expected 1/0", r_beats, r_last_err); else pass_cnt++;
        #1;
        chk_cnt++; if (err !== 1'b1) $display("FAIL err_set: got %b expected 1", err); else pass_cnt++;
        // DECERR with a simultaneous clear: the set must win.
        @(negedge clk);
        drive_burst(32'h0000_2080, 8'd1, 0, 1'b0, 2'b11, 1'b1);
        #1;
        chk_cnt++; if (err !== 1'b1) $display("FAIL err_set_wins: got %b expected 1", err); else pass_cnt++;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk_cnt++; if (err !== 1'b0) $display("FAIL err_clr: got %b expected 0", err); else pass_cnt++;
        @(negedge clk);
        drive_burst(32'h0000_20C0, 8'd0, 0, 1'b0, 2'b01, 1'b0);
        #1;
        chk_cnt++; if (err !== 1'b0) $display("FAIL exokay_no_err: got %b expected 0", err); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        drive_burst(32'h0000_3000, 8'd1, 0, 1'b0, 2'b00, 1'b0);
        #1;
        chk_cnt++; if (done !== 1'b0) $display("FAIL b2b_done_pulse: got %b expected 0", done); else pass_cnt++;
        drive_burst(32'h0000_3100, 8'd2, 0, 1'b0, 2'b00, 1'b0);
        chk_cnt++; if (r_ready_wait !== 0) $display("FAIL b2b_ready_wait: got %0d expected 0", r_ready_wait); else pass_cnt++;
        chk_cnt++; if (r_beats !== 3 || r_done !== 1) $display("FAIL b2b_second: got %0d beats %0d done expected 3/1", r_beats, r_done); else pass_cnt++;
    endtask

    task automatic test_random();
        int bad_beats;
        int bad_other;
        int dones;
        logic [7:0] len;
        logic [AW-1:0] addr;
        bad_beats = 0;
        bad_other = 0;
        dones = 0;
        for (int n = 0; n < 200; n++) begin
            len = 8'($urandom_range(0, 15));
            addr = {$urandom_range(0, 32'hFFFF), 4'h0, 12'($urandom_range(0, 2047))};
            drive_burst(addr, len, 0, 1'b1, 2'b00, 1'b0);
            if (r_beats != int'(len) + 1) bad_beats++;
            bad_other += r_aw_bad + r_data_err + r_last_err + r_ctl_err + r_spur_done + int'(r_timeout);
            if (r_aw_hs != 1) bad_other++;
            dones += r_done;
        end
        chk_cnt++; if (bad_beats !== 0) $display("FAIL rand_beats: got %0d bad bursts expected 0", bad_beats); else pass_cnt++;
        chk_cnt++; if (bad_other !== 0) $display("FAIL rand_protocol: got %0d errors expected 0", bad_other); else pass_cnt++;
        chk_cnt++; if (dones !== 200) $display("FAIL rand_done: got %0d expected 200", dones); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int got;
        int guard;
        cmd_addr = 32'h0000_5000;
        cmd_len = 8'd7;
        cmd_valid = 1'b1;
        #1;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        axi.wready = 1'b1;
        din_valid = 1'b1;
        got = 0;
        guard = 0;
        while (got < 2 && guard < 20) begin
            #1;
            if (din_ready) got++;
            @(negedge clk);
            guard++;
        end
        #1;
        chk_cnt++; if ({busy, axi.awvalid, axi.wvalid} !== 3'b111) $display("FAIL midrst_before: got %b expected 111", {busy, axi.awvalid, axi.wvalid}); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if ({axi.awvalid, axi.wvalid, din_ready, axi.bready, busy} !== 5'b0) $display("FAIL midrst_drop: got %b expected 00000", {axi.awvalid, axi.wvalid, din_ready, axi.bready, busy}); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        din_valid = 1'b0;
        axi.wready = 1'b0;
        @(negedge clk);
        drive_burst(32'h0000_6000, 8'd2, 0, 1'b0, 2'b00, 1'b0);
        chk_cnt++; if (r_beats !== 3 || r_done !== 1 || r_timeout) $display("FAIL midrst_recover: got %0d beats %0d done expected 3/1", r_beats, r_done); else pass_cnt++;
        chk_cnt++; if (r_ctl_err + r_aw_bad + r_data_err !== 0) $display("FAIL midrst_recover_errs: got %0d expected 0", r_ctl_err + r_aw_bad + r_data_err); else pass_cnt++;
    endtask

    task automatic test_4k();
`ifdef AXI_WR_4K_CHECK_EN
        int guard;
        cmd_addr = 32'h0000_0FC0;
        cmd_len = 8'd1;
        cmd_valid = 1'b1;
        din_valid = 1'b1;
        axi.wready = 1'b1;
        axi.awready = 1'b1;
        #1;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk_cnt++; if ({done, err} !== 2'b11) $display("FAIL x4k_done_err: got %b expected 11", {done, err}); else pass_cnt++;
        chk_cnt++; if ({axi.awvalid, axi.wvalid, din_ready, busy} !== 4'b0) $display("FAIL x4k_no_burst: got %b expected 0000", {axi.awvalid, axi.wvalid, din_ready, busy}); else pass_cnt++;
        @(negedge clk);
        #1;
        chk_cnt++; if ({done, cmd_ready, axi.awvalid} !== 3'b010) $display("FAIL x4k_idle: got %b expected 010", {done, cmd_ready, axi.awvalid}); else pass_cnt++;
        din_valid = 1'b0;
        axi.wready = 1'b0;
        axi.awready = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
`else
        drive_burst(32'h0000_0FC0, 8'd1, 0, 1'b0, 2'b00, 1'b0);
        chk_cnt++; if (r_beats !== 2 || r_aw_hs !== 1 || r_timeout) $display("FAIL x4k_issued: got %0d beats %0d aw expected 2/1", r_beats, r_aw_hs); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL x4k_no_err: got %b expected 0", err); else pass_cnt++;
`endif
        // Ends exactly on the page boundary: always a legal burst.
        drive_burst(32'h0000_0F80, 8'd1, 0, 1'b0, 2'b00, 1'b0);
        chk_cnt++; if (r_beats !== 2 || r_done !== 1 || r_timeout) $display("FAIL x4k_edge_ok: got %0d beats %0d done expected 2/1", r_beats, r_done); else pass_cnt++;
        #1;
        chk_cnt++; if (err !== 1'b0) $display("FAIL x4k_edge_err: got %b expected 0", err); else pass_cnt++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got stuck expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_err();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_4k();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
